// File: rtl/spike_count_classifier.sv
// Spike-count output classifier: counts spikes per output neuron over NUM_STEPS
// time steps, then scans for the arg-max. Optional readback port via SPK_COUNT_READBACK_EN.
module spike_count_classifier #(
  parameter int NUM_NEURON = 40,
  parameter int CNT_W      = 8,
  parameter int NUM_STEPS  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             spk,
  input  logic [5:0]       spk_addr,
  input  logic             step_done,
`ifdef SPK_COUNT_READBACK_EN
  input  logic [5:0]       rd_addr,
  output logic [CNT_W-1:0] rd_count,
`endif
  output logic             busy,
  output logic             class_valid,
  output logic [5:0]       class_idx,
  output logic [CNT_W-1:0] class_count,
  output logic             addr_err,
  output logic             sat_flag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt [NUM_NEURON];
  logic [7:0]       r_step;
  logic [6:0]       r_scan_idx;
  logic [5:0]       r_max_idx;
  logic [CNT_W-1:0] r_max_cnt;
  logic             r_class_valid;
  logic [5:0]       r_class_idx;
  logic [CNT_W-1:0] r_class_count;
  logic             r_addr_err;
  logic             r_sat;

  logic             w_start_ok;
  logic             w_run;
  logic             w_addr_ok;
  logic             w_spk_in;
  logic             w_spk_bad;
  logic [CNT_W-1:0] w_tgt_cnt;
  logic [CNT_W-1:0] w_scan_cnt;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_run      = (r_state == S_RUN);
  assign w_addr_ok  = ({1'b0, spk_addr} < 7'(NUM_NEURON));
  assign w_spk_in   = w_run && spk && w_addr_ok;
  assign w_spk_bad  = w_run && spk && !w_addr_ok;

  // Selects the addressed counter and the counter under scan without out-of-range indexing
  always_comb begin
    w_tgt_cnt  = '0;
    w_scan_cnt = '0;
    for (int i = 0; i < NUM_NEURON; i++) begin
      if (spk_addr == 6'(i)) w_tgt_cnt = r_cnt[i];
      if (r_scan_idx == 7'(i)) w_scan_cnt = r_cnt[i];
    end
  end

  // Per-neuron saturating spike counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURON; i++) r_cnt[i] <= '0;
    end else if (w_start_ok) begin
      for (int i = 0; i < NUM_NEURON; i++) r_cnt[i] <= '0;
    end else if (w_spk_in && (w_tgt_cnt != CNT_MAX)) begin
      for (int i = 0; i < NUM_NEURON; i++)
        if (spk_addr == 6'(i)) r_cnt[i] <= r_cnt[i] + CNT_ONE;
    end
  end

  // Sticky error flags, cleared by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
      r_sat      <= 1'b0;
    end else if (w_start_ok) begin
      r_addr_err <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      if (w_spk_bad) r_addr_err <= 1'b1;
      if (w_spk_in && (w_tgt_cnt == CNT_MAX)) r_sat <= 1'b1;
    end
  end

  // Control FSM with arg-max scan; the extra SCAN cycle at idx==NUM_NEURON commits the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_step        <= 8'd0;
      r_scan_idx    <= 7'd0;
      r_max_idx     <= 6'd0;
      r_max_cnt     <= '0;
      r_class_valid <= 1'b0;
      r_class_idx   <= 6'd0;
      r_class_count <= '0;
    end else begin
      r_class_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_step  <= 8'd0;
          end
        end
        S_RUN: begin
          if (step_done) begin
            if (r_step == 8'(NUM_STEPS - 1)) begin
              r_state    <= S_SCAN;
              r_scan_idx <= 7'd0;
              r_max_idx  <= 6'd0;
              r_max_cnt  <= '0;
            end else begin
              r_step <= r_step + 8'd1;
            end
          end
        end
        S_SCAN: begin
          if (r_scan_idx < 7'(NUM_NEURON)) begin
            if (w_scan_cnt > r_max_cnt) begin
              r_max_cnt <= w_scan_cnt;
              r_max_idx <= r_scan_idx[5:0];
            end
            r_scan_idx <= r_scan_idx + 7'd1;
          end else begin
            r_state       <= S_DONE;
            r_class_idx   <= r_max_idx;
            r_class_count <= r_max_cnt;
            r_class_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SPK_COUNT_READBACK_EN
  logic [CNT_W-1:0] r_rd_count;
  logic [CNT_W-1:0] w_rd_cnt;

  // Readback mux; out-of-range addresses fall through to zero
  always_comb begin
    w_rd_cnt = '0;
    for (int i = 0; i < NUM_NEURON; i++)
      if (rd_addr == 6'(i)) w_rd_cnt = r_cnt[i];
  end

  // Registered readback value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_count <= '0;
    else        r_rd_count <= w_rd_cnt;
  end

  assign rd_count = r_rd_count;
`endif

  assign busy        = (r_state == S_RUN) || (r_state == S_SCAN);
  assign class_valid = r_class_valid;
  assign class_idx   = r_class_idx;
  assign class_count = r_class_count;
  assign addr_err    = r_addr_err;
  assign sat_flag    = r_sat;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Self-checking bench for spike_count_classifier (default parameters), with a
// behavioural count/arg-max model; readback checked when SPK_COUNT_READBACK_EN is defined.
module tb_spike_count_classifier;

  localparam int NN = 40;
  localparam int NS = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       spk = 1'b0;
  logic [5:0] spk_addr = 6'd0;
  logic       step_done = 1'b0;
  logic       busy, class_valid, addr_err, sat_flag;
  logic [5:0] class_idx;
  logic [7:0] class_count;
`ifdef SPK_COUNT_READBACK_EN
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] rd_count;
`endif

  spike_count_classifier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spk(spk), .spk_addr(spk_addr),
    .step_done(step_done),
`ifdef SPK_COUNT_READBACK_EN
    .rd_addr(rd_addr), .rd_count(rd_count),
`endif
    .busy(busy), .class_valid(class_valid), .class_idx(class_idx),
    .class_count(class_count), .addr_err(addr_err), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int  vecs = 0;
  int  errs = 0;
  int  m_cnt [NN];
  bit  m_aerr, m_sat;
  bit  got;
  int  lat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_aerr = 0;
    m_sat  = 0;
  endtask

  // Spike accepted while the model is in its counting phase
  task automatic model_spike(input int a);
    if (a >= NN) m_aerr = 1;
    else if (m_cnt[a] == 255) m_sat = 1;
    else m_cnt[a]++;
  endtask

  function automatic int exp_idx();
    int best = 0;
    for (int i = 1; i < NN; i++) if (m_cnt[i] > m_cnt[best]) best = i;
    return best;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  // One cycle of stimulus; the spike is modelled only when counting is live
  task automatic cyc(input bit s, input int a, input bit sd, input bit live);
    spk = s; spk_addr = 6'(a); step_done = sd;
    tick();
    if (s && live) model_spike(a);
    spk = 1'b0; step_done = 1'b0;
  endtask

  // Spreads a list of spikes across the NS steps, then waits for the result
  task automatic run_list(input int lst[$]);
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < lst.size(); k++) if (k % NS == s) cyc(1'b1, lst[k], 1'b0, 1'b1);
      cyc(1'b0, 0, 1'b1, 1'b1);
    end
  endtask

  task automatic wait_result();
    got = 0; lat = 0;
    for (int c = 1; c <= 200 && !got; c++) begin
      tick();
      if (class_valid) begin got = 1; lat = c; end
    end
  endtask

  task automatic test_reset();
    vecs += 6;
    if (busy !== 1'b0)        begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (class_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", class_valid); end
    if (class_idx !== 6'd0)   begin errs++; $display("FAIL reset_idx got=%0d exp=0", class_idx); end
    if (class_count !== 8'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", class_count); end
    if (addr_err !== 1'b0)    begin errs++; $display("FAIL reset_aerr got=%b exp=0", addr_err); end
    if (sat_flag !== 1'b0)    begin errs++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
  endtask

  task automatic test_basic();
    int lst[$] = '{7, 12, 7, 7};
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0);  // step_done in IDLE is ignored
    do_start();
    vecs++;
    if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy got=%b exp=1", busy); end
    run_list(lst);
    wait_result();
    vecs += 4;
    if (!got || lat != NN + 1) begin errs++; $display("FAIL basic_latency got=%0d exp=%0d", lat, NN + 1); end
    if (class_idx !== 6'(exp_idx())) begin errs++; $display("FAIL basic_idx got=%0d exp=%0d", class_idx, exp_idx()); end
    if (class_count !== 8'(m_cnt[exp_idx()])) begin errs++; $display("FAIL basic_count got=%0d exp=%0d", class_count, m_cnt[exp_idx()]); end
    if (class_idx !== 6'd7 || class_count !== 8'd3) begin errs++; $display("FAIL basic_abs got=%0d/%0d exp=7/3", class_idx, class_count); end
    tick();
    vecs += 3;
    if (class_valid !== 1'b0) begin errs++; $display("FAIL basic_pulse got=%b exp=0", class_valid); end
    if (busy !== 1'b0) begin errs++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    if (class_idx !== 6'd7) begin errs++; $display("FAIL basic_hold got=%0d exp=7", class_idx); end
`ifdef SPK_COUNT_READBACK_EN
    rd_addr = 6'd7;
    tick();
    vecs++;
    if (rd_count !== 8'd3) begin errs++; $display("FAIL readback7 got=%0d exp=3", rd_count); end
    rd_addr = 6'd50;
    tick();
    vecs++;
    if (rd_count !== 8'd0) begin errs++; $display("FAIL readback50 got=%0d exp=0", rd_count); end
`endif
  endtask

  task automatic test_tie();
    int lst[$] = '{9, 9, 4, 9, 4, 4, 9, 4, 9, 4};
    do_start();
    run_list(lst);
    wait_result();
    vecs += 2;
    if (!got || class_idx !== 6'd4) begin errs++; $display("FAIL tie_idx got=%0d exp=4", class_idx); end
    if (class_count !== 8'd5) begin errs++; $display("FAIL tie_count got=%0d exp=5", class_count); end
  endtask

  task automatic test_saturation();
    do_start();
    for (int i = 0; i < 260; i++) cyc(1'b1, 2, 1'b0, 1'b1);
    cyc(1'b1, 50, 1'b0, 1'b1);
    for (int s = 0; s < NS; s++) cyc(1'b0, 0, 1'b1, 1'b1);
    wait_result();
    vecs += 4;
    if (!got || class_count !== 8'd255) begin errs++; $display("FAIL sat_count got=%0d exp=255", class_count); end
    if (class_idx !== 6'd2) begin errs++; $display("FAIL sat_idx got=%0d exp=2", class_idx); end
    if (sat_flag !== 1'b1) begin errs++; $display("FAIL sat_flag got=%b exp=1", sat_flag); end
    if (addr_err !== 1'b1) begin errs++; $display("FAIL sat_aerr got=%b exp=1", addr_err); end
  endtask

  task automatic test_coincident();
    do_start();
    for (int s = 0; s < NS - 1; s++) cyc(1'b0, 0, 1'b1, 1'b1);
    cyc(1'b1, 30, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 5, 1'b0, 1'b0);  // SCAN: spikes ignored
    wait_result();
    vecs += 3;
    if (!got || class_idx !== 6'd30) begin errs++; $display("FAIL coinc_idx got=%0d exp=30", class_idx); end
    if (class_count !== 8'd1) begin errs++; $display("FAIL coinc_count got=%0d exp=1", class_count); end
    if (sat_flag !== 1'b0 || addr_err !== 1'b0) begin errs++; $display("FAIL coinc_flags got=%b%b exp=00", sat_flag, addr_err); end
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      do_start();
      for (int s = 0; s < NS; s++) begin
        int n = $urandom_range(4, 0);
        for (int k = 0; k < n; k++) begin
          int a = ($urandom_range(9, 0) == 0) ? $urandom_range(63, NN) : $urandom_range(NN - 1, 0);
          bit st = (s == NS / 2 && k == 0);  // start mid-RUN is ignored
          start = st;
          cyc(1'b1, a, 1'b0, 1'b1);
          start = 1'b0;
        end
        cyc($urandom_range(1, 0) == 1, $urandom_range(NN - 1, 0), 1'b1, 1'b1);
      end
      wait_result();
      vecs += 4;
      if (!got || lat != NN + 1) begin errs++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, lat, NN + 1); end
      if (class_idx !== 6'(exp_idx())) begin errs++; $display("FAIL rnd%0d_idx got=%0d exp=%0d", it, class_idx, exp_idx()); end
      if (class_count !== 8'(m_cnt[exp_idx()])) begin errs++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, class_count, m_cnt[exp_idx()]); end
      if (addr_err !== m_aerr) begin errs++; $display("FAIL rnd%0d_aerr got=%b exp=%b", it, addr_err, m_aerr); end
    end
  endtask

  task automatic test_reset_in_scan();
    bit seen = 0;
    do_start();
    cyc(1'b1, 50, 1'b0, 1'b1);
    cyc(1'b1, 3, 1'b0, 1'b1);
    for (int s = 0; s < NS; s++) cyc(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    vecs++;
    if (busy !== 1'b0 || class_idx !== 6'd0 || class_count !== 8'd0 || class_valid !== 1'b0 ||
        addr_err !== 1'b0 || sat_flag !== 1'b0)
      begin errs++; $display("FAIL rst_scan_outputs got=%b%0d/%0d%b%b%b exp=00/0000", busy, class_idx, class_count, class_valid, addr_err, sat_flag); end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin tick(); if (class_valid) seen = 1; end
    vecs++;
    if (seen) begin errs++; $display("FAIL rst_scan_novalid got=1 exp=0"); end
    do_start();
    for (int s = 0; s < NS; s++) cyc(1'b0, 0, 1'b1, 1'b1);
    wait_result();
    vecs += 2;
    if (!got || class_idx !== 6'd0) begin errs++; $display("FAIL zero_idx got=%0d valid_seen=%b exp=0", class_idx, got); end
    if (class_count !== 8'd0) begin errs++; $display("FAIL zero_count got=%0d exp=0", class_count); end
  endtask

  initial begin
    model_clear();
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_tie();
    test_random(8);
    test_saturation();
    test_coincident();
    test_reset_in_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
